// File: rtl/alu_iter_exec_if.sv
// Interface: alu_iter_exec_if
// Operand/result handshake bundle between the ALU decoder and the execute
// unit. The decoder side uses the master modport, the execute unit the
// slave modport.
interface alu_iter_exec_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_aluop;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_illegal;

  // Producer of operations and consumer of results
  modport master (
    output in_valid,
    output in_aluop,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_illegal
  );

  // The execute unit itself
  modport slave (
    input  in_valid,
    input  in_aluop,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result,
    output out_illegal
  );

endinterface

// File: rtl/alu_iter_exec.sv
// Module: alu_iter_exec
// Execute unit downstream of the ALU decoder. Add/sub, logic, compares and
// pass-B complete in one cycle; shifts walk an accumulator SHIFT_STEP bits
// per cycle so only a narrow shifter is needed instead of a full barrel.
// Every output is a register; in_ready is decoded from the state.
module alu_iter_exec #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input logic            clk,
  input logic            rst_n,
  alu_iter_exec_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(SHIFT_STEP);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRA   = 4'd8,
    OP_SRL   = 4'd9,
    OP_PASSB = 4'd10
  } aluop_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   acc_d;
  logic [SHAMT_W-1:0] cnt_q;
  logic [SHAMT_W-1:0] cnt_d;
  logic [SHAMT_W-1:0] step_amt;
  logic [3:0]         op_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               illegal_q;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_result;
  logic               op_is_shift;
  logic               op_is_illegal;

  assign shamt = bus.in_b[SHAMT_W-1:0];

  // Single-cycle result for the op presented at the input. Shifts with a
  // zero amount simply return operand A, so no barrel shifter is built here.
  always_comb begin
    alu_result    = '0;
    op_is_shift   = 1'b0;
    op_is_illegal = 1'b0;
    case (bus.in_aluop)
      OP_ADD:   alu_result = bus.in_a + bus.in_b;
      OP_SUB:   alu_result = bus.in_a - bus.in_b;
      OP_AND:   alu_result = bus.in_a & bus.in_b;
      OP_OR:    alu_result = bus.in_a | bus.in_b;
      OP_XOR:   alu_result = bus.in_a ^ bus.in_b;
      OP_SLT:   alu_result = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      OP_SLTU:  alu_result = {{(WIDTH-1){1'b0}}, (bus.in_a < bus.in_b)};
      OP_SLL, OP_SRA, OP_SRL: begin
        alu_result  = bus.in_a;
        op_is_shift = 1'b1;
      end
      OP_PASSB: alu_result = bus.in_b;
      default:  op_is_illegal = 1'b1;
    endcase
  end

  // One iteration of the shift walk: move at most SHIFT_STEP bits, never
  // past the remaining count, so the final step can be a partial one.
  always_comb begin
    step_amt = (cnt_q < STEP_C) ? cnt_q : STEP_C;
    acc_d    = acc_q;
    case (op_q)
      OP_SLL:  acc_d = acc_q << step_amt;
      OP_SRL:  acc_d = acc_q >> step_amt;
      OP_SRA:  acc_d = $signed(acc_q) >>> step_amt;
      default: acc_d = acc_q;
    endcase
    cnt_d = cnt_q - step_amt;
  end

  // Control FSM with registered result/valid/illegal outputs. Inputs are
  // only sampled on accept in IDLE; a reset abandons any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (op_is_illegal) begin
              result_q    <= '0;
              illegal_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (op_is_shift && (shamt != '0)) begin
              illegal_q <= 1'b0;
              acc_q     <= bus.in_a;
              cnt_q     <= shamt;
              op_q      <= bus.in_aluop;
              state_q   <= SHIFT;
            end else begin
              illegal_q   <= 1'b0;
              result_q    <= alu_result;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            result_q    <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = result_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Testbench: tb_alu_iter_exec
// Two execute units (SHIFT_STEP 1 and 4) share one stimulus driver; 'sel'
// picks which unit receives in_valid and whose outputs are observed.
// Expected results and latencies are pushed to a scoreboard at send time
// and popped when the selected unit raises out_valid.
module tb_alu_iter_exec;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] result;
    logic         illegal;
    int           lat;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         sel;
  logic         in_valid;
  logic [3:0]   in_aluop;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_ready;

  logic         in_ready_w;
  logic         out_valid_w;
  logic [W-1:0] out_result_w;
  logic         out_illegal_w;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  alu_iter_exec_if #(.WIDTH(W)) bus1 ();
  alu_iter_exec_if #(.WIDTH(W)) bus4 ();

  assign bus1.in_valid  = in_valid & ~sel;
  assign bus1.in_aluop  = in_aluop;
  assign bus1.in_a      = in_a;
  assign bus1.in_b      = in_b;
  assign bus1.out_ready = out_ready;

  assign bus4.in_valid  = in_valid & sel;
  assign bus4.in_aluop  = in_aluop;
  assign bus4.in_a      = in_a;
  assign bus4.in_b      = in_b;
  assign bus4.out_ready = out_ready;

  assign in_ready_w    = sel ? bus4.in_ready    : bus1.in_ready;
  assign out_valid_w   = sel ? bus4.out_valid   : bus1.out_valid;
  assign out_result_w  = sel ? bus4.out_result  : bus1.out_result;
  assign out_illegal_w = sel ? bus4.out_illegal : bus1.out_illegal;

  alu_iter_exec #(.WIDTH(W), .SHIFT_STEP(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  alu_iter_exec #(.WIDTH(W), .SHIFT_STEP(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // 10-unit clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference behaviour: final result and cycles from accept to out_valid
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int step);
    exp_t e;
    int   sh;
    sh        = int'(b[4:0]);
    e.result  = '0;
    e.illegal = 1'b0;
    e.lat     = 1;
    case (op)
      4'd0:    e.result = a + b;
      4'd1:    e.result = a - b;
      4'd2:    e.result = a & b;
      4'd3:    e.result = a | b;
      4'd4:    e.result = a ^ b;
      4'd5:    e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    e.result = (a < b) ? 32'd1 : 32'd0;
      4'd7:    e.result = a << sh;
      4'd8:    e.result = $signed(a) >>> sh;
      4'd9:    e.result = a >> sh;
      4'd10:   e.result = b;
      default: e.illegal = 1'b1;
    endcase
    if (op >= 4'd7 && op <= 4'd9 && sh != 0) e.lat = 1 + (sh + step - 1) / step;
    return e;
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for in_ready, present one op for exactly one edge, then scramble
  // the operand lines so late operand changes would corrupt a bad design.
  task automatic send_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int waitc;
    waitc = 0;
    while (in_ready_w !== 1'b1 && waitc < 100) begin
      tick();
      waitc++;
    end
    checks++;
    if (in_ready_w !== 1'b1) begin
      errors++;
      $display("[TB] FAIL send_ready: in_ready=%b required 1", in_ready_w);
    end
    sb.push_back(model(op, a, b, sel ? 4 : 1));
    in_aluop = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_aluop = 4'($urandom_range(0, 15));
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  // Wait (bounded) for out_valid, pop the scoreboard and compare. If
  // out_ready is high the result is consumed by stepping one more edge.
  task automatic collect(input string name);
    exp_t e;
    int   lat;
    lat = 1;
    while (out_valid_w !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s_sb: scoreboard empty, nothing expected", name);
      return;
    end
    e = sb.pop_front();
    if (out_valid_w !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_valid: out_valid=%b required 1 within 200 cycles", name, out_valid_w);
    end
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("[TB] FAIL %s_latency: got %0d cycles required %0d", name, lat, e.lat);
    end
    checks++;
    if (out_result_w !== e.result) begin
      errors++;
      $display("[TB] FAIL %s_result: got 0x%08h required 0x%08h", name, out_result_w, e.result);
    end
    checks++;
    if (out_illegal_w !== e.illegal) begin
      errors++;
      $display("[TB] FAIL %s_illegal: got %b required %b", name, out_illegal_w, e.illegal);
    end
    if (out_ready) tick();
  endtask

  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    send_op(op, a, b);
    collect(name);
  endtask

  // Reset values on both units while rst_n is held low
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_aluop  = 4'd0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    sel       = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if (in_ready_w !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_in_ready%0d: got %b required 1", s, in_ready_w);
      end
      checks++;
      if (out_valid_w !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_out_valid%0d: got %b required 0", s, out_valid_w);
      end
      checks++;
      if (out_result_w !== '0) begin
        errors++;
        $display("[TB] FAIL reset_result%0d: got 0x%08h required 0", s, out_result_w);
      end
      checks++;
      if (out_illegal_w !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_illegal%0d: got %b required 0", s, out_illegal_w);
      end
    end
    sel = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // Single-cycle ops, including the wrap and signed/unsigned corners
  task automatic test_arith();
    sel       = 1'b0;
    out_ready = 1'b1;
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("sub_wrap", 4'd1, 32'h0000_0000, 32'h0000_0001);
    run_op("slt_neg",  4'd5, 32'h8000_0000, 32'h0000_0001);
    run_op("sltu_big", 4'd6, 32'h8000_0000, 32'h0000_0001);
    run_op("slt_pos",  4'd5, 32'h0000_0001, 32'h8000_0000);
    run_op("and_rnd",  4'd2, $urandom, $urandom);
    run_op("or_rnd",   4'd3, $urandom, $urandom);
    run_op("xor_rnd",  4'd4, $urandom, $urandom);
    run_op("add_rnd",  4'd0, $urandom, $urandom);
    run_op("passb",    4'd10, 32'hCAFE_0000, 32'h1234_5678);
  endtask

  // Iterative shifts on the one-bit-per-cycle unit
  task automatic test_shift_step1();
    sel       = 1'b0;
    out_ready = 1'b1;
    run_op("sra31_s1", 4'd8, 32'h8000_0000, 32'd31);
    run_op("srl31_s1", 4'd9, 32'h8000_0000, 32'd31);
    run_op("sll1_s1",  4'd7, 32'hF000_0001, 32'd1);
    run_op("sra0_s1",  4'd8, 32'h8765_4321, 32'hFFFF_FFE0);
    run_op("sll_rnd",  4'd7, $urandom, $urandom);
    run_op("sra_rnd",  4'd8, $urandom, $urandom);
  endtask

  // Multi-bit steps, including a partial final step
  task automatic test_shift_step4();
    sel       = 1'b1;
    out_ready = 1'b1;
    run_op("sll5_s4",  4'd7, 32'h0000_0001, 32'h0000_0025);
    run_op("sll0_s4",  4'd7, 32'hDEAD_BEEF, 32'h0000_0020);
    run_op("sra31_s4", 4'd8, 32'h8000_0000, 32'd31);
    run_op("srl4_s4",  4'd9, 32'hA5A5_A5A5, 32'd4);
    run_op("sra7_s4",  4'd8, 32'h9234_5678, 32'd7);
    run_op("srl_rnd4", 4'd9, $urandom, $urandom);
    sel = 1'b0;
  endtask

  // Result held under back-pressure, in_valid ignored in DONE, then the
  // illegal op and the clearing of out_illegal by the next legal op
  task automatic test_backpressure();
    sel       = 1'b0;
    out_ready = 1'b0;
    send_op(4'd10, 32'h0BAD_0BAD, 32'h1234_5678);
    collect("bp_first");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_aluop = 4'd0;
      in_a     = $urandom;
      in_b     = $urandom;
      tick();
      checks++;
      if (out_valid_w !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_valid%0d: got %b required 1", i, out_valid_w);
      end
      checks++;
      if (out_result_w !== 32'h1234_5678) begin
        errors++;
        $display("[TB] FAIL bp_result%0d: got 0x%08h required 0x12345678", i, out_result_w);
      end
      checks++;
      if (in_ready_w !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_in_ready%0d: got %b required 0", i, in_ready_w);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid_w !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release_valid: got %b required 0", out_valid_w);
    end
    checks++;
    if (in_ready_w !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release_ready: got %b required 1", in_ready_w);
    end
    run_op("illegal15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("illegal11", 4'd11, 32'h1111_1111, 32'h2222_2222);
    run_op("legal_after_illegal", 4'd1, 32'd10, 32'd3);
  endtask

  // Asynchronous reset while shifting drops everything immediately
  task automatic test_reset_mid_shift();
    sel       = 1'b0;
    out_ready = 1'b1;
    send_op(4'd8, 32'h8000_0000, 32'd31);
    repeat (5) tick();
    checks++;
    if (in_ready_w !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_shift_busy: in_ready=%b required 0", in_ready_w);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_w !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_valid: got %b required 0", out_valid_w);
    end
    checks++;
    if (in_ready_w !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_ready: got %b required 1", in_ready_w);
    end
    sb.delete();
    #1;
    rst_n = 1'b1;
    tick();
    run_op("after_reset_srl", 4'd9, 32'h8000_0000, 32'd31);
  endtask

  // Random ops on both units with out_ready held high; each result must be
  // followed directly by an IDLE cycle
  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      sel = 1'($urandom_range(0, 1));
      run_op("b2b", 4'($urandom_range(0, 15)), $urandom, $urandom);
      checks++;
      if (in_ready_w !== 1'b1 || out_valid_w !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_idle%0d: in_ready=%b out_valid=%b required 1/0", i, in_ready_w, out_valid_w);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift_step1();
    test_shift_step4();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: %0d results never produced, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
